// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - FSM state, grant encoding and byte-enable constants shared by the memory arbiter
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_DM = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_DM = 1'b1
  } grant_t;

  // Wide enough for any supported DW; users slice the low DW/8 bits.
  localparam int BE_MAX = 128;
  localparam logic [BE_MAX-1:0] BE_WORD = '1;

endpackage

// File: rtl/riscv_arb_pick.sv
// rtl/riscv_arb_pick.sv - winner select between fetch and data requests
// RISCV_MEM_ARB_RR_EN: round-robin on ties (last_grant flop); otherwise fixed DM priority.
module riscv_arb_pick
  import riscv_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dm_req,
  input  logic take,
  output logic valid,
  output logic grant
);

  assign valid = if_req | dm_req;

`ifdef RISCV_MEM_ARB_RR_EN
  grant_t last_grant;

  // Reset to DM so the first tie after reset goes to IF.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GRANT_DM;
    end else if (take && valid) begin
      last_grant <= grant_t'(grant);
    end
  end

  always_comb begin
    grant = GRANT_IF;
    if (if_req && dm_req) begin
      grant = (last_grant == GRANT_DM) ? GRANT_IF : GRANT_DM;
    end else if (dm_req) begin
      grant = GRANT_DM;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = clk ^ rst ^ take;

  always_comb begin
    grant = GRANT_IF;
    if (dm_req) begin
      grant = GRANT_DM;
    end
  end
`endif

endmodule

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - shares one single-port variable-latency memory between IF and DM ports
// Define RISCV_MEM_ARB_RR_EN for round-robin tie-breaking instead of fixed DM priority.
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ack,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [DW/8-1:0] dm_be,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  output logic [DW-1:0]   dm_rdata,
  output logic            dm_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready,
  output logic            busy
);

  arb_state_t state_q, state_d;
  logic       resp_dm_q;
  logic       pick_valid;
  logic       pick_grant;
  logic       take;

  assign take = (state_q == IDLE) && pick_valid;

  riscv_arb_pick u_pick (
    .clk    (clk),
    .rst    (rst),
    .if_req (if_req),
    .dm_req (dm_req),
    .take   (take),
    .valid  (pick_valid),
    .grant  (pick_grant)
  );

  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    busy    = 1'b0;
    if_ack  = 1'b0;
    dm_ack  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = (pick_grant == GRANT_DM) ? GNT_DM : GNT_IF;
        end
      end
      GNT_IF, GNT_DM: begin
        mem_req = 1'b1;
        busy    = 1'b1;
        if (mem_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        busy    = 1'b1;
        if_ack  = ~resp_dm_q;
        dm_ack  = resp_dm_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side fields are captured once at grant and held for the whole access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      resp_dm_q <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        resp_dm_q <= (pick_grant == GRANT_DM);
        if (pick_grant == GRANT_DM) begin
          mem_we    <= dm_we;
          mem_be    <= dm_be;
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
        end else begin
          mem_we    <= 1'b0;
          mem_be    <= BE_WORD[DW/8-1:0];
          mem_addr  <= if_addr;
          mem_wdata <= '0;
        end
      end
      if (mem_ready && (state_q == GNT_IF)) begin
        if_rdata <= mem_rdata;
      end
      if (mem_ready && (state_q == GNT_DM)) begin
        dm_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - scoreboard bench for riscv_mem_arbiter (both RISCV_MEM_ARB_RR_EN builds)
module tb_riscv_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [BW-1:0] dm_be = '0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          mem_req;
  logic          mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          busy;

  riscv_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            dm;
    logic [DW-1:0] if_rd;
    logic [DW-1:0] dm_rd;
    int            cyc;
  } ack_t;

  typedef struct {
    logic          we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  ack_t ack_q[$];
  acc_t acc_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference timeline: a grant sampled in cycle g with W wait cycles drives
  // mem_req over g+1..g+1+W, acks in g+2+W, and the next grant may be sampled at g+3+W.
  int            cyc = 0;
  int            free_at = 0;
  int            g_cyc = -100;
  int            g_w = 0;
  int            w_force = -1;
  int            s;
  bit            take_dm;
  bit            m_last_dm = 1'b1;
  logic [DW-1:0] m_if_rd = '0;
  logic [DW-1:0] m_dm_rd = '0;
  logic [DW-1:0] m_rdata = '0;
  acc_t          na;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    s = cyc;
    if (rst) begin
      ack_q.delete();
      acc_q.delete();
      free_at   = s + 1;
      g_cyc     = -100;
      m_if_rd   = '0;
      m_dm_rd   = '0;
      m_last_dm = 1'b1;
    end else if (s >= free_at && (if_req || dm_req)) begin
      if (if_req && dm_req) begin
`ifdef RISCV_MEM_ARB_RR_EN
        take_dm = !m_last_dm;
`else
        take_dm = 1'b1;
`endif
      end else begin
        take_dm = dm_req;
      end
      m_last_dm = take_dm;
      g_cyc     = s;
      g_w       = (w_force >= 0) ? w_force : int'($urandom_range(0, 3));
      m_rdata   = $urandom;
      free_at   = s + 3 + g_w;
      if (take_dm) begin
        na.we = dm_we; na.be = dm_be; na.addr = dm_addr; na.wdata = dm_wdata;
        m_dm_rd = m_rdata;
      end else begin
        na.we = 1'b0; na.be = {BW{1'b1}}; na.addr = if_addr; na.wdata = '0;
        m_if_rd = m_rdata;
      end
      acc_q.push_back(na);
      ack_q.push_back('{take_dm, m_if_rd, m_dm_rd, s + 2 + g_w});
    end
    cyc = cyc + 1;
    #1;
    mem_ready = (cyc == g_cyc + 1 + g_w);
    mem_rdata = mem_ready ? m_rdata : DW'($urandom);
  end

  // Monitor: per-cycle handshake timing plus scoreboard pops on mem_req rise and on acks.
  initial begin
    ack_t a;
    acc_t cur;
    logic mem_req_prev;
    mem_req_prev = 1'b0;
    cur = '{1'b0, '0, '0, '0};
    forever begin
      @(negedge clk);
      chk("mem_req_timing", mem_req, (cyc >= g_cyc + 1) && (cyc <= g_cyc + 1 + g_w));
      chk("busy_timing", busy, (cyc >= g_cyc + 1) && (cyc <= g_cyc + 2 + g_w));
      if (mem_req && !mem_req_prev) begin
        chk("mem_access_expected", acc_q.size() > 0, 1);
        if (acc_q.size() > 0) cur = acc_q.pop_front();
      end
      if (mem_req) begin
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_we", mem_we, cur.we);
        chk("mem_be", mem_be, cur.be);
        chk("mem_wdata", mem_wdata, cur.wdata);
      end
      mem_req_prev = mem_req;
      if (if_ack || dm_ack) begin
        chk("ack_expected", ack_q.size() > 0, 1);
        if (ack_q.size() > 0) begin
          a = ack_q.pop_front();
          chk("ack_port", {if_ack, dm_ack}, a.dm ? 2'b01 : 2'b10);
          chk("ack_cycle", cyc, a.cyc);
          chk("if_rdata", if_rdata, a.if_rd);
          chk("dm_rdata", dm_rdata, a.dm_rd);
        end
      end
    end
  end

  task automatic if_txn(input logic [AW-1:0] addr);
    bit done = 1'b0;
    if_req  = 1'b1;
    if_addr = addr;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (rst || if_ack) done = 1'b1;
    end
    chk("if_ack_within_bound", done, 1);
    @(posedge clk);
    #1;
    if_req = 1'b0;
  endtask

  task automatic dm_txn(input logic we, input logic [BW-1:0] be,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bit done = 1'b0;
    dm_req   = 1'b1;
    dm_we    = we;
    dm_be    = be;
    dm_addr  = addr;
    dm_wdata = wdata;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (rst || dm_ack) done = 1'b1;
    end
    chk("dm_ack_within_bound", done, 1);
    @(posedge clk);
    #1;
    dm_req = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_if_ack"}, if_ack, 0);
    chk({tag, "_dm_ack"}, dm_ack, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_be"}, mem_be, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_dm_rdata"}, dm_rdata, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    w_force = 0;
    if_txn(32'h10);
    w_force = 3;
    dm_txn(1'b1, 4'b0011, 32'h100, 32'hDEADBEEF);

    w_force = 1;
    repeat (2) begin
      fork
        if_txn(32'h20);
        dm_txn(1'b0, 4'b1111, 32'h200, 32'h0);
      join
      gap(1);
    end

    w_force = 0;
    if_txn(32'h0);
    if_txn(32'h4);
    w_force = 1;
    dm_txn(1'b0, 4'b1111, 32'h200, 32'h0);

    w_force = 20;
    fork
      dm_txn(1'b1, 4'b1111, 32'h300, 32'h55AA55AA);
      begin
        gap(3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join

    w_force = -1;
    fork
      repeat (40) begin
        gap($urandom_range(0, 2));
        if_txn({$urandom_range(0, 255), 2'b00});
      end
      repeat (40) begin
        gap($urandom_range(0, 2));
        dm_txn(1'($urandom), 4'($urandom), $urandom, $urandom);
      end
    join

    gap(6);
    chk("ack_queue_drained", ack_q.size(), 0);
    chk("acc_queue_drained", acc_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
